// File: rtl/crystals_pkg.sv
// Shared types, constants and modular-normalisation helpers for the NTT datapath.
// DATA_WIDTH, Q and MUL_STAGE_CNT default to Dilithium values unless predefined as macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 23
`endif
`ifndef Q
`define Q 8380417
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 3
`endif

package crystals_pkg;
    localparam int          DATA_WIDTH    = `DATA_WIDTH;
    localparam int unsigned Q             = `Q;
    localparam int          MUL_STAGE_CNT = `MUL_STAGE_CNT;
    localparam int          N             = 256;
    localparam int          BF_PER_LAYER  = N / 2;

    typedef logic [DATA_WIDTH-1:0]      coeff_t;
    typedef logic signed [DATA_WIDTH:0] mres_t;

    localparam logic [DATA_WIDTH:0] Q_U     = (DATA_WIDTH+1)'(Q);
    localparam mres_t               Q_S     = mres_t'(Q_U);
    localparam mres_t               NEG_Q_S = -Q_S;

    // Inputs canonical in [0,Q); the extra bit absorbs the carry.
    function automatic coeff_t mod_norm_add(input coeff_t a, input coeff_t b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_U)
            s = s - Q_U;
        return coeff_t'(s);
    endfunction

    function automatic coeff_t mod_norm_sub(input coeff_t a, input coeff_t b);
        mres_t d;
        d = mres_t'({1'b0, a}) - mres_t'({1'b0, b});
        if (d[DATA_WIDTH])
            d = d + Q_S;
        return coeff_t'(d);
    endfunction
endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a qualifying valid bit; only the valid bits are reset.
module delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++)
                valid_q[i] <= valid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++)
            data_q[i] <= data_q[i-1];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/bf_addsub.sv
// Cooley-Tukey butterfly back-end behind mo_mul: aligns a, normalises t, emits (a+t, a-t) mod Q.
// Define BF_RANGE_CHECK_EN to enable the sticky range_err check on mul_res.
module bf_addsub
    import crystals_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic signed [DATA_WIDTH:0] mul_res,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic [DATA_WIDTH-1:0] out_diff,
    output logic                  out_last,
    output logic                  range_err
);
    localparam int                IDX_W    = $clog2(BF_PER_LAYER);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BF_PER_LAYER - 1);

    logic       al_valid;
    coeff_t     al_a;
    mres_t      t_ext;
    coeff_t     t_norm;
    logic       n1_valid;
    coeff_t     n1_a;
    coeff_t     n1_t;
    logic [IDX_W-1:0] bf_idx;

    delay_line #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MUL_STAGE_CNT)
    ) u_align (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_a),
        .out_valid (al_valid),
        .out_data  (al_a)
    );

    // mul_res is contracted to [-Q,Q), so a single conditional add lands in [0,Q).
    always_comb begin
        t_ext  = mul_res[DATA_WIDTH] ? (mul_res + Q_S) : mul_res;
        t_norm = coeff_t'(t_ext);
    end

    always_ff @(posedge clk) begin
        if (rst)
            n1_valid <= 1'b0;
        else
            n1_valid <= al_valid;
    end

    always_ff @(posedge clk) begin
        if (al_valid) begin
            n1_a <= al_a;
            n1_t <= t_norm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_diff  <= '0;
            out_last  <= 1'b0;
            bf_idx    <= '0;
        end else begin
            out_valid <= n1_valid;
            out_last  <= n1_valid && (bf_idx == LAST_IDX);
            if (n1_valid) begin
                out_sum  <= mod_norm_add(n1_a, n1_t);
                out_diff <= mod_norm_sub(n1_a, n1_t);
                bf_idx   <= (bf_idx == LAST_IDX) ? '0 : bf_idx + 1'b1;
            end
        end
    end

`ifdef BF_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (al_valid && ((mul_res < NEG_Q_S) || (mul_res >= Q_S))) begin
            range_err <= 1'b1;
`ifndef SYNTHESIS
            $display("bf_addsub: mul_res out of range: %0d", mul_res);
`endif
        end
    end
`else
    assign range_err = 1'b0;
`endif
endmodule
